ext_mem_driver: RTL and testbench
=================================

Name: ext_mem_driver

Overview:
- Initiator-side adapter for the 70-bit packed external memory port.
- Accepts load/store commands from a core-side valid/ready interface and registers each one into a put request on `mem_arg`.
- Tracks outstanding requests and polls responses with get handshakes on `mem_out`.
- Buffers responses in a small FIFO toward the consumer. Sits between a Kôika core's memory interface and the memory wrapper.

Parameters:
- MAX_OUTSTANDING, 4, max puts issued without a matching get (1..15)
- RSP_DEPTH, 2, response FIFO entries (power of 2, >=2)

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted this cycle when high with cmd_valid
- cmd_byte_en  input  4  byte enables; 0 = load, nonzero = store
- cmd_addr  input  32  byte address
- cmd_data  input  32  store data (don't-care for loads)
- rsp_valid  output  1  response at FIFO head
- rsp_ready  input  1  consumer takes head
- rsp_byte_en  output  4  echoed byte enables
- rsp_addr  output  32  echoed address
- rsp_data  output  32  load data / store echo
- mem_arg  output  70  {get_valid, put_valid, put_request[67:0]}; put_request = {byte_en[3:0], addr[31:0], data[31:0]}
- mem_out  input  70  {get_ready, put_ready, get_response[67:0]}, same 68-bit layout

Behaviour:
- One clock (CLK); reset RST is synchronous, active-high.
- Reset values:
  - req_full = 0, so put_valid = 0.
  - outstanding = 0, so get_valid = 0.
  - Response FIFO empty, so rsp_valid = 0.
  - put_request = 0.
  - Asserting RST mid-transaction drops all in-flight state. Memory-side responses pending at that point are not collected, and the memory is reset with the same RST.
- Request register (1 entry):
  - put_fire = put_valid & put_ready.
  - cmd_fire = cmd_valid & cmd_ready.
  - Issue condition: cmd_ready = (~req_full | put_fire) & (outstanding_next_cap < MAX_OUTSTANDING), where outstanding_next_cap = outstanding + req_full.
  - On cmd_fire: load {byte_en, addr, data} into the register and set req_full. Otherwise put_fire clears req_full.
  - Latency: a command accepted in cycle N is offered on put_valid in cycle N+1.
  - put_request holds stable while put_valid=1 and put_ready=0.
- Outstanding counter (4 bits):
  - +1 on put_fire, -1 on get_fire, unchanged when both fire in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
  - A get_fire with outstanding=0 cannot occur, because get_valid is gated.
- Get side:
  - get_valid = (outstanding != 0) & ~rsp_full.
  - get_fire = get_valid & get_ready; it pushes get_response into the FIFO the same cycle.
  - Responses return in issue order (the memory is in-order); one response per put, loads and stores alike.
- Response FIFO:
  - rsp_* driven from the head.
  - pop = rsp_valid & rsp_ready.
  - Simultaneous push and pop when full is not allowed, because get_valid is low when full. Simultaneous push and pop otherwise keeps count unchanged.
  - Minimum latency: get_fire in cycle M gives rsp_valid in cycle M+1.
- Pointers wrap modulo RSP_DEPTH; count width = clog2(RSP_DEPTH)+1.
- No combinational path from mem_out to cmd_ready other than through put_ready.

Optional Feature:
- Macro: EXT_MEM_DRV_STATS_EN.
- When defined, adds outputs:
  - stat_puts[31:0]: counts put_fire, wraps at 2^32.
  - stat_gets[31:0]: counts get_fire, wraps at 2^32.
  - stat_max_out[3:0]: high-water mark of outstanding.
  - All are cleared by RST.
- When undefined, these ports and registers are absent and the block's behaviour is otherwise identical.

Test Plan:
- Reset, then one load:
  - Stimulus: after RST, cmd {0, 0x100, x}; memory put_ready=1; response data 0xDEADBEEF.
  - Required: put_valid high the cycle after acceptance; outstanding 0→1→0; rsp_valid with rsp_addr=0x100, rsp_data=0xDEADBEEF.
- Backpressure:
  - Stimulus: put_ready=0 for 5 cycles, then a store {0xF, 0x200, 0x12345678} is accepted.
  - Required: put_request stable for all 5 cycles; cmd_ready=0 while the register is full; exactly one put_fire.
- Outstanding cap:
  - Stimulus: MAX_OUTSTANDING=4, get_ready=0, 6 back-to-back commands.
  - Required: exactly 4 put_fire; cmd_ready low afterward; after one get_fire, one more put is issued.
- Response FIFO full:
  - Stimulus: RSP_DEPTH=2, rsp_ready=0, 3 requests issued, get_ready=1.
  - Required: 2 gets, then get_valid=0; raising rsp_ready drains in order and the third get follows.
- Simultaneous put_fire and get_fire with outstanding=2:
  - Required: outstanding stays 2; order of addresses 0x0, 0x4, 0x8 preserved at rsp.
- Mid-operation reset:
  - Stimulus: RST for 1 cycle with outstanding=3 and FIFO holding 1 entry.
  - Required: next cycle put_valid=0, get_valid=0, rsp_valid=0; with EXT_MEM_DRV_STATS_EN, counters read 0.

Source files
------------

// File: rtl/ext_mem_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_driver_if
//  Purpose  : Core command/response channels plus the packed 70-bit memory port.
//  Revision : 1.0
// ============================================================================
interface ext_mem_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_byte_en;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_byte_en;
    logic [31:0] rsp_addr;
    logic [31:0] rsp_data;

    // mem_arg = {get_valid, put_valid, put_request}; mem_out = {get_ready, put_ready, get_response}
    logic [69:0] mem_arg;
    logic [69:0] mem_out;

    modport master (
        input  cmd_valid, cmd_byte_en, cmd_addr, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_byte_en, rsp_addr, rsp_data,
        input  rsp_ready,
        output mem_arg,
        input  mem_out
    );

    modport slave (
        output cmd_valid, cmd_byte_en, cmd_addr, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_byte_en, rsp_addr, rsp_data,
        output rsp_ready,
        input  mem_arg,
        output mem_out
    );
endinterface
`default_nettype wire

// File: rtl/ext_mem_driver.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_driver
//  Purpose  : Initiator adapter: core load/store commands -> put/get memory port.
//             Optional statistics outputs enabled by EXT_MEM_DRV_STATS_EN.
//  Revision : 1.0
// ============================================================================
module ext_mem_driver #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int RSP_DEPTH       = 2
) (
    input  logic             CLK,
    input  logic             RST,
    ext_mem_driver_if.master bus
`ifdef EXT_MEM_DRV_STATS_EN
    ,
    output logic [31:0]      stat_puts,
    output logic [31:0]      stat_gets,
    output logic [3:0]       stat_max_out
`endif
);
    localparam int                 c_PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [4:0]         c_MAX_OUT = 5'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(RSP_DEPTH);

    logic               r_req_full;
    logic [67:0]        r_req;
    logic [3:0]         r_outstanding;
    logic [67:0]        r_fifo [RSP_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_put_ready;
    logic               w_get_ready;
    logic [67:0]        w_get_response;
    logic               w_put_fire;
    logic               w_get_fire;
    logic               w_get_valid;
    logic               w_cmd_ready;
    logic               w_cmd_fire;
    logic               w_rsp_valid;
    logic               w_rsp_full;
    logic               w_pop;
    logic [4:0]         w_out_cap;
    logic [3:0]         w_out_next;

    assign w_get_ready    = bus.mem_out[69];
    assign w_put_ready    = bus.mem_out[68];
    assign w_get_response = bus.mem_out[67:0];

    assign w_rsp_valid = (r_count != '0);
    assign w_rsp_full  = (r_count == c_DEPTH);
    assign w_pop       = w_rsp_valid & bus.rsp_ready;

    assign w_put_fire  = r_req_full & w_put_ready;
    assign w_get_valid = (r_outstanding != 4'd0) & ~w_rsp_full;
    assign w_get_fire  = w_get_valid & w_get_ready;

    // A request sitting in the register already counts against the cap.
    assign w_out_cap   = {1'b0, r_outstanding} + {4'd0, r_req_full};
    assign w_cmd_ready = (~r_req_full | w_put_fire) & (w_out_cap < c_MAX_OUT);
    assign w_cmd_fire  = bus.cmd_valid & w_cmd_ready;

    always_comb begin
        w_out_next = r_outstanding;
        if (w_put_fire && !w_get_fire) begin
            w_out_next = r_outstanding + 4'd1;
        end else if (!w_put_fire && w_get_fire) begin
            w_out_next = r_outstanding - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_req_full    <= 1'b0;
            r_req         <= 68'd0;
            r_outstanding <= 4'd0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_cmd_fire) begin
                r_req      <= {bus.cmd_byte_en, bus.cmd_addr, bus.cmd_data};
                r_req_full <= 1'b1;
            end else if (w_put_fire) begin
                r_req_full <= 1'b0;
            end
        end
    end

    // Response FIFO: pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_get_fire) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_get_fire, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_get_fire) begin
            r_fifo[r_wr_ptr] <= w_get_response;
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.mem_arg     = {w_get_valid, r_req_full, r_req};
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_byte_en = r_fifo[r_rd_ptr][67:64];
    assign bus.rsp_addr    = r_fifo[r_rd_ptr][63:32];
    assign bus.rsp_data    = r_fifo[r_rd_ptr][31:0];

`ifdef EXT_MEM_DRV_STATS_EN
    logic [31:0] r_stat_puts;
    logic [31:0] r_stat_gets;
    logic [3:0]  r_stat_max_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_puts    <= 32'd0;
            r_stat_gets    <= 32'd0;
            r_stat_max_out <= 4'd0;
        end else begin
            if (w_put_fire) begin
                r_stat_puts <= r_stat_puts + 32'd1;
            end
            if (w_get_fire) begin
                r_stat_gets <= r_stat_gets + 32'd1;
            end
            if (w_out_next > r_stat_max_out) begin
                r_stat_max_out <= w_out_next;
            end
        end
    end

    assign stat_puts    = r_stat_puts;
    assign stat_gets    = r_stat_gets;
    assign stat_max_out = r_stat_max_out;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ext_mem_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_mem_driver
//  Purpose  : Randomized bench for ext_mem_driver against a queue-level model.
//  Revision : 1.0
// ============================================================================
module tb_ext_mem_driver;
    localparam int MAXO  = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    ext_mem_driver_if bus();
`ifdef EXT_MEM_DRV_STATS_EN
    logic [31:0] stat_puts;
    logic [31:0] stat_gets;
    logic [3:0]  stat_max_out;
`endif

    ext_mem_driver #(.MAX_OUTSTANDING(MAXO), .RSP_DEPTH(DEPTH)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
`ifdef EXT_MEM_DRV_STATS_EN
        ,
        .stat_puts    (stat_puts),
        .stat_gets    (stat_gets),
        .stat_max_out (stat_max_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus knobs
    bit d_rst, d_cmd_en, d_put_ready, d_get_ready, d_rsp_ready;
    logic [67:0] cmd_src[$];

    // Reference model: request slot, in-flight count, response FIFO, memory
    logic [67:0] pend[$];
    logic [67:0] rfifo[$];
    logic [67:0] mq[$];
    logic [31:0] mem[logic [31:0]];
    int          outst;
    bit          model_ok;
    logic [31:0] m_puts, m_gets;
    int          m_max;

    int          n_cmp, n_bad, n_put, n_get;
    bit          s_cmd_ready;
    logic [31:0] popped[$];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [67:0] rand_cmd();
        logic [3:0]  be;
        logic [31:0] a;
        be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        a  = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
        return {be, a, 32'($urandom)};
    endfunction

    function automatic bit is_idle();
        return cmd_src.size() == 0 && pend.size() == 0 && outst == 0 && rfifo.size() == 0;
    endfunction

    task automatic step();
        bit          cv, gr;
        bit          e_put_valid, e_get_valid, e_rsp_valid, e_cmd_ready;
        bit          put_f, get_f, pop_f, cmd_f;
        logic [67:0] cw, req;
        logic [31:0] word;
        cv = d_cmd_en && cmd_src.size() != 0;
        cw = cv ? cmd_src[0] : {4'($urandom), 32'($urandom), 32'($urandom)};
        gr = d_get_ready && mq.size() != 0;
        rst             = d_rst;
        bus.cmd_valid   = cv;
        bus.cmd_byte_en = cw[67:64];
        bus.cmd_addr    = cw[63:32];
        bus.cmd_data    = cw[31:0];
        bus.rsp_ready   = d_rsp_ready;
        bus.mem_out     = {gr, d_put_ready, (mq.size() != 0) ? mq[0] : 68'h0};
        #1;
        e_put_valid = pend.size() != 0;
        put_f       = e_put_valid && d_put_ready;
        e_cmd_ready = (!e_put_valid || put_f) && (outst + pend.size() < MAXO);
        e_get_valid = outst != 0 && rfifo.size() < DEPTH;
        get_f       = e_get_valid && gr;
        e_rsp_valid = rfifo.size() != 0;
        pop_f       = e_rsp_valid && d_rsp_ready;
        cmd_f       = cv && e_cmd_ready;
        s_cmd_ready = bus.cmd_ready;
        if (model_ok) begin
            chk("cmd_ready", bus.cmd_ready, e_cmd_ready);
            chk("put_valid", bus.mem_arg[68], e_put_valid);
            chk("get_valid", bus.mem_arg[69], e_get_valid);
            chk("rsp_valid", bus.rsp_valid, e_rsp_valid);
            if (e_put_valid) chk("put_request", bus.mem_arg[67:0], pend[0]);
            if (e_rsp_valid) chk("rsp_fields", {bus.rsp_byte_en, bus.rsp_addr, bus.rsp_data}, rfifo[0]);
`ifdef EXT_MEM_DRV_STATS_EN
            chk("stat_puts", stat_puts, m_puts);
            chk("stat_gets", stat_gets, m_gets);
            chk("stat_max_out", stat_max_out, 4'(m_max));
`endif
        end
        if (pop_f) popped.push_back(bus.rsp_addr);
        if (put_f) n_put++;
        if (get_f) n_get++;
        @(posedge clk);
        if (d_rst) begin
            pend.delete(); rfifo.delete(); mq.delete();
            outst = 0; m_puts = 0; m_gets = 0; m_max = 0;
            model_ok = 1'b1;
        end else begin
            if (pop_f) void'(rfifo.pop_front());
            if (get_f) rfifo.push_back(mq.pop_front());
            if (put_f) begin
                req  = pend.pop_front();
                word = mem.exists(req[63:32]) ? mem[req[63:32]] : 32'h0;
                if (req[67:64] == 4'h0) begin
                    mq.push_back({req[67:32], word});
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (req[64+b]) word[8*b +: 8] = req[8*b +: 8];
                    mem[req[63:32]] = word;
                    mq.push_back(req);
                end
                m_puts++;
            end
            if (get_f) m_gets++;
            if (cmd_f) pend.push_back(cw);
            outst = outst + int'(put_f) - int'(get_f);
            if (outst > m_max) m_max = outst;
        end
        if (cmd_f) void'(cmd_src.pop_front());
        @(negedge clk);
    endtask

    task automatic idle_cfg();
        d_cmd_en = 0; d_put_ready = 1; d_get_ready = 1; d_rsp_ready = 1;
    endtask

    task automatic drain(int budget);
        idle_cfg();
        cmd_src.delete();
        for (int i = 0; i < budget; i++) begin
            if (is_idle()) break;
            step();
        end
        chk("drain_timeout", is_idle(), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; n_put = 0; n_get = 0;
        outst = 0; model_ok = 0; m_puts = 0; m_gets = 0; m_max = 0;
        mem[32'h100] = 32'hDEADBEEF;
        idle_cfg();
        d_rst = 1;
        @(negedge clk);
        repeat (3) step();
        d_rst = 0;
        chk("rst_put_valid", bus.mem_arg[68], 0);
        chk("rst_get_valid", bus.mem_arg[69], 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_put_request", bus.mem_arg[67:0], 0);

        // Single load after reset
        idle_cfg();
        cmd_src.push_back({4'h0, 32'h100, 32'h0});
        d_cmd_en = 1;
        for (int i = 0; i < 10 && cmd_src.size() != 0; i++) step();
        chk("load_put_valid_next", bus.mem_arg[68], 1);
        chk("load_put_request", bus.mem_arg[67:0], {4'h0, 32'h100, 32'h0});
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) break;
            step();
        end
        chk("load_rsp_addr", bus.rsp_addr, 32'h100);
        chk("load_rsp_data", bus.rsp_data, 32'hDEADBEEF);
        drain(50);

        // Backpressure on the put side
        idle_cfg();
        d_put_ready = 0;
        cmd_src.push_back({4'hF, 32'h200, 32'h12345678});
        cmd_src.push_back(rand_cmd());
        d_cmd_en = 1;
        step();
        n_put = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_put_request", bus.mem_arg[67:0], {4'hF, 32'h200, 32'h12345678});
            step();
            chk("bp_cmd_ready_low", s_cmd_ready, 0);
        end
        d_put_ready = 1;
        step();
        chk("bp_single_put", n_put, 1);
        drain(50);

        // Outstanding cap
        idle_cfg();
        d_get_ready = 0;
        repeat (8) cmd_src.push_back(rand_cmd());
        d_cmd_en = 1;
        n_put = 0;
        repeat (10) step();
        chk("cap_puts", n_put, 4);
        chk("cap_cmd_ready_low", s_cmd_ready, 0);
        d_get_ready = 1;
        step();
        d_get_ready = 0;
        repeat (4) step();
        chk("cap_put_after_get", n_put, 5);
        drain(100);

        // Response FIFO full
        idle_cfg();
        d_rsp_ready = 0;
        repeat (3) cmd_src.push_back(rand_cmd());
        d_cmd_en = 1;
        n_get = 0;
        repeat (12) step();
        chk("ff_gets", n_get, 2);
        chk("ff_get_valid_low", bus.mem_arg[69], 0);
        d_rsp_ready = 1;
        repeat (6) step();
        chk("ff_third_get", n_get, 3);
        drain(50);

        // Simultaneous put and get with two in flight
        idle_cfg();
        d_get_ready = 0;
        popped.delete();
        cmd_src.push_back({4'h0, 32'h0, 32'h0});
        cmd_src.push_back({4'h0, 32'h4, 32'h0});
        cmd_src.push_back({4'h0, 32'h8, 32'h0});
        d_cmd_en = 1;
        repeat (3) step();
        d_get_ready = 1;
        n_put = 0; n_get = 0;
        step();
        chk("sim_put_fire", n_put, 1);
        chk("sim_get_fire", n_get, 1);
        drain(50);
        chk("sim_rsp_count", popped.size(), 3);
        if (popped.size() == 3)
            chk("sim_rsp_order", {popped[0], popped[1], popped[2]}, {32'h0, 32'h4, 32'h8});

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (cmd_src.size() < 2) cmd_src.push_back(rand_cmd());
            d_cmd_en    = $urandom_range(0, 99) < 70;
            d_put_ready = $urandom_range(0, 99) < 60;
            d_get_ready = $urandom_range(0, 99) < 60;
            d_rsp_ready = $urandom_range(0, 99) < 60;
            step();
        end
        drain(200);

        // Reset with three in flight and one buffered response
        idle_cfg();
        d_get_ready = 0; d_rsp_ready = 0;
        repeat (4) cmd_src.push_back(rand_cmd());
        d_cmd_en = 1;
        repeat (7) step();
        d_get_ready = 1;
        step();
        d_get_ready = 0; d_cmd_en = 0;
        chk("mr_pre_rsp_valid", bus.rsp_valid, 1);
        d_rst = 1;
        step();
        d_rst = 0;
        chk("mr_put_valid", bus.mem_arg[68], 0);
        chk("mr_get_valid", bus.mem_arg[69], 0);
        chk("mr_rsp_valid", bus.rsp_valid, 0);
`ifdef EXT_MEM_DRV_STATS_EN
        chk("mr_stat_puts", stat_puts, 0);
        chk("mr_stat_gets", stat_gets, 0);
        chk("mr_stat_max", stat_max_out, 0);
`endif
        cmd_src.delete();
        for (int c = 0; c < 200; c++) begin
            if (cmd_src.size() < 2) cmd_src.push_back(rand_cmd());
            d_cmd_en    = $urandom_range(0, 99) < 70;
            d_put_ready = $urandom_range(0, 99) < 70;
            d_get_ready = $urandom_range(0, 99) < 70;
            d_rsp_ready = $urandom_range(0, 99) < 70;
            step();
        end
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
